compare_filter: RTL and testbench

Persistence filter that sits directly downstream of the magnitude comparator and turns its raw lt/eq/gt flags into a debounced, registered relationship code. A new relationship is accepted only after it has been seen on HOLD consecutive qualified samples. Each accepted change produces a one-cycle event pulse and increments a saturating change counter. The block feeds the status/display logic of the design.

---
 rtl/compare_pkg.sv | 43 ++++
 rtl/sat_counter.sv | 56 +++++
 rtl/compare_filter.sv | 168 ++++++++++++++++
 tb/tb_compare_filter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// compare_pkg: shared definitions for the comparator result path.
// Holds the 2-bit relationship codes used by the comparator consumers and the
// display logic, the persistence-filter FSM encodings, and the flag decode
// helpers.
package compare_pkg;

    // Width of a relationship code.
    localparam int CODE_W = 2;

    // Width of the internal persistence run counter (HOLD is at most 255).
    localparam int RUN_W = 8;

    // Relationship codes.
    localparam logic [CODE_W-1:0] RES_NONE = 2'b00;
    localparam logic [CODE_W-1:0] RES_LT   = 2'b01;
    localparam logic [CODE_W-1:0] RES_EQ   = 2'b10;
    localparam logic [CODE_W-1:0] RES_GT   = 2'b11;

    // Filter state, derived from the valid/candidate/result registers.
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_TRACKING = 2'b01,
        ST_PENDING  = 2'b10
    } filt_state_e;

    // True when exactly one of {lt, eq, gt} is set.
    function automatic logic flags_one_hot(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

    // Map {lt, eq, gt} to a relationship code; non-one-hot patterns give NONE.
    function automatic logic [CODE_W-1:0] flags_to_code(input logic [2:0] flags);
        logic [CODE_W-1:0] code;
        case (flags)
            3'b100:  code = RES_LT;
            3'b010:  code = RES_EQ;
            3'b001:  code = RES_GT;
            default: code = RES_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that saturates at a runtime limit.
// Ports:
//   clk    system clock, rising-edge state updates
//   reset  synchronous active-high reset (count -> 0)
//   inc    increment request (no effect once count has reached limit)
//   clr    clear request; clr together with inc loads 1 (clear, then increment)
//   limit  saturation value
//   count  registered counter value
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next-value selection: clear first, then a saturating increment.
    always_comb begin
        count_next_s = count_r;
        if (clr && inc) begin
            if (limit == {WIDTH{1'b0}}) begin
                count_next_s = {WIDTH{1'b0}};
            end else begin
                count_next_s = {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end else if (clr) begin
            count_next_s = {WIDTH{1'b0}};
        end else if (inc) begin
            if (count_r < limit) begin
                count_next_s = count_r + {{(WIDTH-1){1'b0}}, 1'b1};
            end else begin
                count_next_s = count_r;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/compare_filter.sv
// compare_filter: persistence filter for the magnitude comparator flags.
// A relationship code is accepted once it has been seen on HOLD consecutive
// qualified samples; each accepted change pulses `change` and bumps a
// saturating change counter.
// Ports:
//   clk          system clock, rising-edge state updates
//   reset        synchronous active-high reset
//   lt, eq, gt   raw comparator flags
//   sample_en    qualifies the flags for this cycle
//   clear_count  synchronous clear of count
//   result       accepted code (00 NONE, 01 LT, 10 EQ, 11 GT)
//   valid        a result has been accepted since reset
//   change       one-cycle pulse after a new result is accepted
//   error        one-cycle pulse after a non-one-hot qualified sample
//   count        number of accepted changes, saturating at all-ones
module compare_filter
    import compare_pkg::*;
#(
    parameter int HOLD   = 4,
    parameter int CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lt,
    input  logic              eq,
    input  logic              gt,
    input  logic              sample_en,
    input  logic              clear_count,
    output logic [CODE_W-1:0] result,
    output logic              valid,
    output logic              change,
    output logic              error,
    output logic [CWIDTH-1:0] count
);

    localparam logic [RUN_W-1:0] HOLD_LIM    = RUN_W'(HOLD);
    localparam logic             HOLD_IS_ONE = (HOLD == 1) ? 1'b1 : 1'b0;

    logic [2:0]        flags_s;
    logic              code_ok_s;
    logic [CODE_W-1:0] code_s;
    logic              bad_sample_s;
    logic              run_hit_same_s;

    logic              run_inc_s;
    logic              run_clr_s;
    logic              accept_s;
    logic [CODE_W-1:0] cand_next_s;
    logic [CODE_W-1:0] result_next_s;
    filt_state_e       state_next_s;

    logic [RUN_W-1:0]  run_r;
    logic [CODE_W-1:0] cand_r;
    logic [CODE_W-1:0] result_r;
    logic              change_r;
    logic              error_r;
    filt_state_e       state_r;
    logic [CWIDTH-1:0] count_r;

    assign flags_s      = {lt, eq, gt};
    assign code_ok_s    = flags_one_hot(flags_s);
    assign code_s       = flags_to_code(flags_s);
    assign bad_sample_s = sample_en && !code_ok_s;

    // The run saturates at HOLD, so "updated run == HOLD" is run+1 >= HOLD;
    // widened by one bit so run+1 cannot wrap.
    assign run_hit_same_s = ({1'b0, run_r} + {{RUN_W{1'b0}}, 1'b1}) >= {1'b0, HOLD_LIM};

    // Candidate tracking and acceptance decision for the current sample.
    always_comb begin
        run_inc_s     = 1'b0;
        run_clr_s     = 1'b0;
        accept_s      = 1'b0;
        cand_next_s   = cand_r;
        result_next_s = result_r;
        if (bad_sample_s) begin
            run_clr_s   = 1'b1;
            cand_next_s = RES_NONE;
        end else if (sample_en) begin
            run_inc_s = 1'b1;
            if (code_s == cand_r) begin
                accept_s = run_hit_same_s && (code_s != result_r);
            end else begin
                // clr with inc restarts the run at one for the new candidate
                run_clr_s   = 1'b1;
                cand_next_s = code_s;
                accept_s    = HOLD_IS_ONE && (code_s != result_r);
            end
            if (accept_s) begin
                result_next_s = code_s;
            end else begin
                result_next_s = result_r;
            end
        end else begin
            cand_next_s   = cand_r;
            result_next_s = result_r;
        end
    end

    // Filter state: unlocked until the first accept, then tracks whether the
    // candidate agrees with the accepted result.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_UNLOCKED: begin
                if (accept_s) begin
                    state_next_s = ST_TRACKING;
                end else begin
                    state_next_s = ST_UNLOCKED;
                end
            end
            ST_TRACKING, ST_PENDING: begin
                if (cand_next_s == result_next_s) begin
                    state_next_s = ST_TRACKING;
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            default: state_next_s = ST_UNLOCKED;
        endcase
    end

    // Filter registers and output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_UNLOCKED;
            cand_r   <= RES_NONE;
            result_r <= RES_NONE;
            change_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cand_r   <= cand_next_s;
            result_r <= result_next_s;
            change_r <= accept_s;
            error_r  <= bad_sample_s;
        end
    end

    sat_counter #(
        .WIDTH (RUN_W)
    ) u_run (
        .clk   (clk),
        .reset (reset),
        .inc   (run_inc_s),
        .clr   (run_clr_s),
        .limit (HOLD_LIM),
        .count (run_r)
    );

    sat_counter #(
        .WIDTH (CWIDTH)
    ) u_count (
        .clk   (clk),
        .reset (reset),
        .inc   (accept_s),
        .clr   (clear_count),
        .limit ({CWIDTH{1'b1}}),
        .count (count_r)
    );

    assign result = result_r;
    assign valid  = (state_r != ST_UNLOCKED);
    assign change = change_r;
    assign error  = error_r;
    assign count  = count_r;

endmodule

// File: tb/tb_compare_filter.sv
// tb_compare_filter: directed bench for compare_filter. Two instances share the
// stimulus: dut_a (HOLD=4, CWIDTH=8) and dut_b (HOLD=1, CWIDTH=2). A streak-based
// reference model predicts every output of both each cycle; literal checks at
// key points pin the model to hand-derived values.
module tb_compare_filter;

    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_LT   = 3'b100;
    localparam logic [2:0] F_EQ   = 3'b010;
    localparam logic [2:0] F_GT   = 3'b001;
    localparam logic [2:0] F_LTEQ = 3'b110;

    logic clk = 1'b0;
    logic reset, lt, eq, gt, sample_en, clear_count;

    logic [1:0] result_a, result_b;
    logic       valid_a, valid_b, change_a, change_b, error_a, error_b;
    logic [7:0] count_a;
    logic [1:0] count_b;

    int checks   = 0;
    int failures = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    compare_filter #(.HOLD(4), .CWIDTH(8)) dut_a (
        .clk(clk), .reset(reset), .lt(lt), .eq(eq), .gt(gt),
        .sample_en(sample_en), .clear_count(clear_count),
        .result(result_a), .valid(valid_a), .change(change_a),
        .error(error_a), .count(count_a)
    );

    compare_filter #(.HOLD(1), .CWIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .lt(lt), .eq(eq), .gt(gt),
        .sample_en(sample_en), .clear_count(clear_count),
        .result(result_b), .valid(valid_b), .change(change_b),
        .error(error_b), .count(count_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: per instance, a streak length of identical valid codes.
    int m_hold[2] = '{4, 1};
    int m_max[2]  = '{255, 3};
    int m_cand[2], m_streak[2], m_result[2], m_valid[2];
    int m_change[2], m_error[2], m_count[2];
    int m_code;
    bit m_acc;
    bit armed = 1'b0;

    // Advance the model on each rising edge, then compare both DUTs just after it.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_cand[i] = 0; m_streak[i] = 0; m_result[i] = 0; m_valid[i] = 0;
                m_change[i] = 0; m_error[i] = 0; m_count[i] = 0;
            end else begin
                m_acc = 1'b0;
                m_change[i] = 0;
                m_error[i] = 0;
                if (sample_en) begin
                    if (int'(lt) + int'(eq) + int'(gt) != 1) begin
                        m_error[i] = 1;
                        m_cand[i] = 0;
                        m_streak[i] = 0;
                    end else begin
                        m_code = lt ? 1 : (eq ? 2 : 3);
                        if (m_code == m_cand[i]) m_streak[i]++;
                        else begin
                            m_cand[i] = m_code;
                            m_streak[i] = 1;
                        end
                        m_acc = (m_streak[i] >= m_hold[i]) && (m_code != m_result[i]);
                        if (m_acc) begin
                            m_result[i] = m_code;
                            m_valid[i] = 1;
                            m_change[i] = 1;
                        end
                    end
                end
                if (clear_count) m_count[i] = 0;
                if (m_acc && m_count[i] < m_max[i]) m_count[i]++;
            end
        end
        if (reset) armed = 1'b1;
        #1;
        if (armed) begin
            check("a_result", 32'(result_a), m_result[0]);
            check("a_valid",  32'(valid_a),  m_valid[0]);
            check("a_change", 32'(change_a), m_change[0]);
            check("a_error",  32'(error_a),  m_error[0]);
            check("a_count",  32'(count_a),  m_count[0]);
            check("b_result", 32'(result_b), m_result[1]);
            check("b_valid",  32'(valid_b),  m_valid[1]);
            check("b_change", 32'(change_b), m_change[1]);
            check("b_error",  32'(error_b),  m_error[1]);
            check("b_count",  32'(count_b),  m_count[1]);
        end
    end

    // Apply one cycle of inputs and wait until the following falling edge.
    task automatic step(input logic [2:0] f, input logic en, input logic clr, input logic rst);
        {lt, eq, gt} = f;
        sample_en    = en;
        clear_count  = clr;
        reset        = rst;
        @(negedge clk);
    endtask

    logic [2:0] seq2[7] = '{F_GT, F_GT, F_GT, F_LT, F_GT, F_GT, F_GT};
    logic [2:0] seq5[5] = '{F_LT, F_GT, F_LT, F_GT, F_LT};
    int         cnt5[5] = '{1, 2, 3, 3, 3};

    // Directed stimulus with hand-computed expectations.
    initial begin
        {lt, eq, gt} = F_NONE;
        sample_en = 1'b0; clear_count = 1'b0; reset = 1'b1;

        // Reset state
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        check("rst_result", 32'(result_a), 32'd0);
        check("rst_valid",  32'(valid_a),  32'd0);
        check("rst_change", 32'(change_a), 32'd0);
        check("rst_error",  32'(error_a),  32'd0);
        check("rst_count",  32'(count_a),  32'd0);

        // Four GT samples: accepted on the 4th edge
        for (int k = 0; k < 3; k++) step(F_GT, 1'b1, 1'b0, 1'b0);
        check("gt3_result", 32'(result_a), 32'd0);
        step(F_GT, 1'b1, 1'b0, 1'b0);
        check("gt4_result", 32'(result_a), 32'd3);
        check("gt4_valid",  32'(valid_a),  32'd1);
        check("gt4_change", 32'(change_a), 32'd1);
        check("gt4_count",  32'(count_a),  32'd1);
        check("gt_b_count", 32'(count_b),  32'd1);
        step(F_GT, 1'b1, 1'b0, 1'b0);
        check("gt5_change", 32'(change_a), 32'd0);

        // Interrupted runs never reach HOLD
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            step(seq2[k], 1'b1, 1'b0, 1'b0);
            check("intr_valid",  32'(valid_a),  32'd0);
            check("intr_change", 32'(change_a), 32'd0);
        end

        // EQ accepted, then a two-hot sample restarts the run
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(F_EQ, 1'b1, 1'b0, 1'b0);
        check("eq_result", 32'(result_a), 32'd2);
        step(F_LTEQ, 1'b1, 1'b0, 1'b0);
        check("bad_error",  32'(error_a),  32'd1);
        check("bad_result", 32'(result_a), 32'd2);
        for (int k = 0; k < 3; k++) step(F_LT, 1'b1, 1'b0, 1'b0);
        check("lt3_result", 32'(result_a), 32'd2);
        check("lt3_error",  32'(error_a),  32'd0);
        step(F_LT, 1'b1, 1'b0, 1'b0);
        check("lt4_result", 32'(result_a), 32'd1);
        check("lt4_change", 32'(change_a), 32'd1);
        check("lt4_count",  32'(count_a),  32'd2);

        // Gapped sample_en: 4 qualified samples over 7 edges
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 6; k++) step(F_LT, (k % 2) == 1, 1'b0, 1'b0);
        check("gap6_result", 32'(result_a), 32'd0);
        step(F_LT, 1'b1, 1'b0, 1'b0);
        check("gap7_result", 32'(result_a), 32'd1);
        check("gap7_change", 32'(change_a), 32'd1);
        step(F_LT, 1'b0, 1'b0, 1'b0);
        check("gap8_change", 32'(change_a), 32'd0);

        // Counter saturation on the 2-bit, HOLD=1 instance
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(seq5[k], 1'b1, 1'b0, 1'b0);
            check("sat_count",  32'(count_b),  32'(cnt5[k]));
            check("sat_change", 32'(change_b), 32'd1);
        end
        step(F_EQ, 1'b1, 1'b1, 1'b0);
        check("clr_acc_count", 32'(count_b), 32'd1);

        // Reset on the 3rd matching sample discards the run
        step(F_NONE, 1'b0, 1'b0, 1'b1);
        step(F_LT, 1'b1, 1'b0, 1'b0);
        step(F_LT, 1'b1, 1'b0, 1'b0);
        step(F_LT, 1'b1, 1'b0, 1'b1);
        check("midrst_result", 32'(result_a), 32'd0);
        check("midrst_valid",  32'(valid_a),  32'd0);
        check("midrst_change", 32'(change_a), 32'd0);
        for (int k = 0; k < 3; k++) step(F_LT, 1'b1, 1'b0, 1'b0);
        check("post3_result", 32'(result_a), 32'd0);
        step(F_LT, 1'b1, 1'b0, 1'b0);
        check("post4_result", 32'(result_a), 32'd1);
        check("post4_change", 32'(change_a), 32'd1);
        check("post4_count",  32'(count_a),  32'd1);

        // clear_count alone
        step(F_NONE, 1'b0, 1'b1, 1'b0);
        check("clr_count", 32'(count_a), 32'd0);
        check("clr_keep_result", 32'(result_a), 32'd1);
        step(F_NONE, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
